rtc_bus_arbiter: RTL
====================

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 SHALL have parameter PHASE_CYC, default 8: clock cycles per bus phase; legal range 2..255.
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port rd_req  in  1  read requester: level request.
REQ-005 SHALL have port rd_addr  in  8  RTC register address to read.
REQ-006 SHALL have port rd_gnt  out  1  one-cycle pulse: read request accepted.
REQ-007 SHALL have port rd_done  out  1  one-cycle pulse: read complete.
REQ-008 SHALL have port rd_data  out  8  last read result.
REQ-009 SHALL have port wr_req  in  1  write requester: level request.
REQ-010 SHALL have port wr_addr  in  8  RTC register address to write.
REQ-011 SHALL have port wr_data  in  8  data to write.
REQ-012 SHALL have port wr_gnt  out  1  one-cycle pulse: write request accepted.
REQ-013 SHALL have port wr_done  out  1  one-cycle pulse: write complete.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have ports CS, AD, RD, WR  out  1 each  active-low RTC strobes, registered.
REQ-016 SHALL have port DatAdd  inout  8  multiplexed RTC address/data bus.

Function
REQ-017 SHALL implement states IDLE, ADDR, GAP, DATA, RECOV; each non-IDLE state lasts exactly PHASE_CYC cycles, timed by an 8-bit counter.
REQ-018 SHALL sample requests only in IDLE: if exactly one is asserted, that request is accepted; if both are asserted, the requester not served last wins. The last-served pointer resets to "read", so the write wins the first tie.
REQ-019 On acceptance, SHALL latch the address (and wr_data for writes), enter ADDR, and pulse the matching gnt during the first ADDR cycle.
REQ-020 ADDR: CS=0, AD=0, WR=0, RD=1; DatAdd drives the latched address.
REQ-021 GAP: CS=0, AD=1, WR=1, RD=1; DatAdd is high-Z.
REQ-022 DATA, read: CS=0, AD=1, RD=0, WR=1; DatAdd is high-Z; rd_data captures DatAdd on the last DATA cycle.
REQ-023 DATA, write: CS=0, AD=1, WR=0, RD=1; DatAdd drives the latched wr_data.
REQ-024 RECOV: all strobes are 1 and DatAdd is high-Z. The matching done pulse is asserted on the last RECOV cycle, and the FSM then returns to IDLE.
REQ-025 A transaction occupies 4*PHASE_CYC cycles from the gnt cycle through the done cycle inclusive. IDLE lasts at least one cycle between transactions.
REQ-026 A requester SHALL deassert req on the cycle it observes done. A req still high in the following IDLE cycle is treated as a new request.
REQ-027 Changes to the latched addr/data inputs after gnt SHALL have no effect on the transaction in progress.
REQ-028 DatAdd SHALL never be driven while RD=0. Strobe outputs SHALL change only at phase boundaries.
REQ-029 rd_data SHALL hold its value until the next read completes; writes never alter it.
REQ-030 In IDLE: CS=AD=RD=WR=1, DatAdd is high-Z, busy=0.

Reset
REQ-031 When reset=0, SHALL immediately (without waiting for clk) force: state IDLE, counter 0, CS=AD=RD=WR=1, DatAdd high-Z, gnt/done/busy=0, rd_data=0x00, last-served pointer = read.
REQ-032 Reset mid-transaction SHALL abort it with no done pulse. Requests pending at reset are re-arbitrated after reset=1, starting from the first IDLE cycle.

Verification
REQ-033 Single read, PHASE_CYC=4, rd_addr=0x21, bus model returns 0x59 -> AD=0 with DatAdd=0x21 for cycles 1-4; RD=0 for cycles 9-12; rd_done at cycle 16; rd_data=0x59.
REQ-034 Single write, wr_addr=0x22, wr_data=0x30 -> model sees address 0x22 latched on the AD/WR strobe, then data 0x30 on the WR strobe with AD=1; wr_done at cycle 16; rd_data unchanged.
REQ-035 rd_req and wr_req both asserted from the first cycle after reset and held -> order is write, read, write, read; each gnt is a single-cycle pulse.
REQ-036 reset=0 asynchronously mid-DATA of a read -> all strobes go 1 and DatAdd goes Z before the next clk edge; no rd_done; rd_data=0x00.
REQ-037 Contention monitor, random requests with PHASE_CYC=2 and PHASE_CYC=255 -> DatAdd is never driven while RD=0, and busy=0 exactly when the state is IDLE.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// Arbiter between one read and one write requester sharing a multiplexed
// RTC bus (address and data on DatAdd, active-low CS/AD/RD/WR strobes).
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   rd_req, rd_addr     read request (level) and register address
//   rd_gnt, rd_done     one-cycle pulses: read accepted / read complete
//   rd_data             result of the most recent completed read
//   wr_req, wr_addr,
//   wr_data             write request (level), register address and data
//   wr_gnt, wr_done     one-cycle pulses: write accepted / write complete
//   busy                high whenever a transaction is in progress
//   CS, AD, RD, WR      registered active-low RTC strobes
//   DatAdd              bidirectional address/data bus
//
// A transaction walks ADDR, GAP, DATA and RECOV, each lasting PHASE_CYC
// cycles. A request is accepted only in IDLE.
module rtc_bus_arbiter #(
    parameter int unsigned PHASE_CYC = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_gnt,
    output logic       rd_done,
    output logic [7:0] rd_data,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_gnt,
    output logic       wr_done,
    output logic       busy,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    inout  wire  [7:0] DatAdd
);

    localparam logic [7:0] LastCnt = 8'(PHASE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StGap,
        StData,
        StRecov
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       is_wr_q, is_wr_d;
    logic       last_wr_q, last_wr_d;   // last-served pointer: 1 = write
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       cs_q, cs_d;
    logic       ad_q, ad_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       drv_q, drv_d;
    logic [7:0] bus_q, bus_d;
    logic       phase_end;

    assign phase_end = (cnt_q == LastCnt);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                // On a tie the write wins unless it was served last.
                if (wr_req && (!rd_req || !last_wr_q)) begin
                    state_d   = StAddr;
                    is_wr_d   = 1'b1;
                    last_wr_d = 1'b1;
                    addr_d    = wr_addr;
                    wdata_d   = wr_data;
                end else if (rd_req) begin
                    state_d   = StAddr;
                    is_wr_d   = 1'b0;
                    last_wr_d = 1'b0;
                    addr_d    = rd_addr;
                end
            end
            StAddr, StGap, StData, StRecov: begin
                if (phase_end) begin
                    cnt_d = 8'd0;
                    case (state_q)
                        StAddr:  state_d = StGap;
                        StGap:   state_d = StData;
                        StData:  state_d = StRecov;
                        default: state_d = StIdle;
                    endcase
                    if (state_q == StData && !is_wr_q) begin
                        rd_data_d = DatAdd;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Strobes and bus drive are decoded from the next state so the registered
    // outputs line up exactly with the state register.
    always_comb begin
        cs_d  = 1'b1;
        ad_d  = 1'b1;
        rd_d  = 1'b1;
        wr_d  = 1'b1;
        drv_d = 1'b0;
        bus_d = addr_d;
        unique case (state_d)
            StAddr: begin
                cs_d  = 1'b0;
                ad_d  = 1'b0;
                wr_d  = 1'b0;
                drv_d = 1'b1;
                bus_d = addr_d;
            end
            StGap: begin
                cs_d = 1'b0;
            end
            StData: begin
                cs_d = 1'b0;
                if (is_wr_d) begin
                    wr_d  = 1'b0;
                    drv_d = 1'b1;
                    bus_d = wdata_d;
                end else begin
                    rd_d = 1'b0;
                end
            end
            StIdle, StRecov: begin
                cs_d = 1'b1;
            end
            default: begin
                cs_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            is_wr_q   <= 1'b0;
            last_wr_q <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            rd_data_q <= 8'd0;
            cs_q      <= 1'b1;
            ad_q      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            drv_q     <= 1'b0;
            bus_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            cs_q      <= cs_d;
            ad_q      <= ad_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            drv_q     <= drv_d;
            bus_q     <= bus_d;
        end
    end

    assign rd_gnt  = (state_q == StAddr) && (cnt_q == 8'd0) && !is_wr_q;
    assign wr_gnt  = (state_q == StAddr) && (cnt_q == 8'd0) && is_wr_q;
    assign rd_done = (state_q == StRecov) && phase_end && !is_wr_q;
    assign wr_done = (state_q == StRecov) && phase_end && is_wr_q;
    assign busy    = (state_q != StIdle);
    assign rd_data = rd_data_q;
    assign CS      = cs_q;
    assign AD      = ad_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign DatAdd  = drv_q ? bus_q : 8'hzz;

endmodule
